seven_segment_scan: RTL and testbench

Parametrised multi-channel 7-segment scan driver. It is the successor of the fixed 4-digit, 2-input display driver. It time-multiplexes DIGITS hex digits from one of CHANNELS packed input words onto a common-anode display. It adds frame-coherent input snapshots, manual or auto-rotating channel selection, per-digit decimal points, leading-zero blanking and an anti-ghost blanking gap. It sits between the datapath registers and the board anode/cathode pins.

---
 rtl/seven_segment_scan_if.sv | 28 ++
 rtl/seven_segment_scan.sv | 158 +++++++++++++++
 tb/tb_seven_segment_scan.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_if.sv
// Display-side bundle of the scan driver: channel words, display controls
// and the anode/cathode/status outputs. master = data source, slave = driver.
interface seven_segment_scan_if #(
  parameter int DIGITS   = 4,
  parameter int CHANNELS = 2
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*DIGITS*4-1:0] ch_data;
  logic [DIGITS-1:0]            dp_mask;
  logic [CW-1:0]                ch_sel;
  logic                         auto_mode;
  logic                         lz_blank;
  logic [DIGITS-1:0]            Anode_Activate;
  logic [7:0]                   LED_out;
  logic [CW-1:0]                active_ch;
  logic                         frame_tick;

  modport master (
    output ch_data, dp_mask, ch_sel, auto_mode, lz_blank,
    input  Anode_Activate, LED_out, active_ch, frame_tick
  );

  modport slave (
    input  ch_data, dp_mask, ch_sel, auto_mode, lz_blank,
    output Anode_Activate, LED_out, active_ch, frame_tick
  );
endinterface

// File: rtl/seven_segment_scan.sv
// Multi-channel common-anode 7-segment scan driver with frame snapshots.
// Ports: clock_100Mhz, reset (sync, active-low), bus (slave side of _if).
module seven_segment_scan #(
  parameter int DIGITS       = 4,
  parameter int CHANNELS     = 2,
  parameter int REFRESH_BITS = 18,
  parameter int BLANK_CYCLES = 1024,
  parameter int AUTO_FRAMES  = 64
) (
  input logic                 clock_100Mhz,
  input logic                 reset,
  seven_segment_scan_if.slave bus
);

  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  localparam int DW = DIGITS * 4;
  localparam logic [SW-1:0] TOP = SW'(DIGITS - 1);

  logic [REFRESH_BITS-1:0] pre_q, pre_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [FW-1:0]           fc_q, fc_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [DW-1:0]           word_q, word_d;
  logic [DIGITS-1:0]       dp_q, dp_d;
  logic                    lz_q, lz_d;
  logic                    tick_q;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [7:0]              led_q, led_d;

  logic              frame_start;
  logic [DW-1:0]     sel_word;
  logic [DIGITS-1:0] blank;
  logic              zrun;
  logic [3:0]        nib;

  function automatic logic [6:0] seg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    unique case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign frame_start = (slot_q == TOP) && (pre_q == '0);

  always_comb begin
    pre_d  = pre_q + 1'b1;
    slot_d = slot_q;
    if (pre_q == '1)
      slot_d = (slot_q == '0) ? TOP : slot_q - 1'b1;
  end

  always_comb begin
    ch_d = ch_q;
    fc_d = fc_q;
    if (frame_start) begin
      if (!bus.auto_mode) begin
        fc_d = '0;
        ch_d = (32'(bus.ch_sel) >= CHANNELS) ? '0 : bus.ch_sel;
      end else if (32'(fc_q) + 1 >= AUTO_FRAMES) begin
        fc_d = '0;
        ch_d = (32'(ch_q) >= CHANNELS - 1) ? '0 : ch_q + 1'b1;
      end else begin
        fc_d = fc_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (32'(ch_d) == c)
        sel_word = bus.ch_data[c*DW +: DW];
  end

  // The snapshot's next value feeds the display so the frame-start
  // cycle already sees the word captured for the new frame.
  always_comb begin
    word_d = word_q;
    dp_d   = dp_q;
    lz_d   = lz_q;
    if (frame_start) begin
      word_d = sel_word;
      dp_d   = bus.dp_mask;
      lz_d   = bus.lz_blank;
    end
  end

  // Zero run scanned from the leftmost digit; any lit dp breaks it.
  always_comb begin
    blank = '0;
    zrun  = lz_d;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zrun     = zrun & (word_d[k*4 +: 4] == 4'd0) & ~dp_d[k];
      blank[k] = (k != 0) & zrun;
    end
  end

  always_comb begin
    nib   = word_d[{slot_q, 2'b00} +: 4];
    an_d  = '1;
    led_d = 8'hFF;
    if (32'(pre_q) >= BLANK_CYCLES && !blank[slot_q]) begin
      an_d[slot_q] = 1'b0;
      led_d        = {~dp_d[slot_q], seg(nib)};
    end
  end

  always_ff @(posedge clock_100Mhz) begin
    if (!reset) begin
      pre_q  <= '0;
      slot_q <= TOP;
      fc_q   <= '0;
      ch_q   <= '0;
      word_q <= '0;
      dp_q   <= '0;
      lz_q   <= 1'b0;
      tick_q <= 1'b0;
      an_q   <= '1;
      led_q  <= 8'hFF;
    end else begin
      pre_q  <= pre_d;
      slot_q <= slot_d;
      fc_q   <= fc_d;
      ch_q   <= ch_d;
      word_q <= word_d;
      dp_q   <= dp_d;
      lz_q   <= lz_d;
      tick_q <= frame_start;
      an_q   <= an_d;
      led_q  <= led_d;
    end
  end

  assign bus.Anode_Activate = an_q;
  assign bus.LED_out        = led_q;
  assign bus.active_ch      = ch_q;
  assign bus.frame_tick     = tick_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan: directed scenarios then random inputs,
// all checked every cycle against a frame-level reference model.
module tb_seven_segment_scan;

  localparam int D  = 4;
  localparam int C  = 3;
  localparam int RB = 3;
  localparam int BC = 2;
  localparam int AF = 2;
  localparam int SLOT  = 1 << RB;
  localparam int FRAME = SLOT * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scan_if #(.DIGITS(D), .CHANNELS(C)) bus ();

  seven_segment_scan #(
    .DIGITS(D), .CHANNELS(C), .REFRESH_BITS(RB),
    .BLANK_CYCLES(BC), .AUTO_FRAMES(AF)
  ) dut (
    .clock_100Mhz(clk),
    .reset(rst_n),
    .bus(bus)
  );

  logic [6:0] GLY [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_tests = 0;
  int n_fail  = 0;

  int          n;
  logic [15:0] s_w;
  logic [3:0]  s_dp;
  logic        s_lz;
  int          m_ch;
  int          m_cnt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // Output during interval n shows the scan position of interval n-1.
  function automatic void model_out(output logic [3:0] an,
                                    output logic [7:0] led);
    int pos, p, s;
    logic z;
    an  = 4'hF;
    led = 8'hFF;
    if (n == 0) return;
    pos = n - 1;
    p   = pos % SLOT;
    s   = D - 1 - (pos / SLOT) % D;
    if (p < BC) return;
    z = s_lz && (s != 0);
    for (int j = s; j < D; j++)
      if (s_w[j*4 +: 4] != 4'd0 || s_dp[j]) z = 1'b0;
    if (z) return;
    an[s] = 1'b0;
    led   = {~s_dp[s], GLY[s_w[s*4 +: 4]]};
  endfunction

  task automatic model_capture();
    if (bus.auto_mode) begin
      m_cnt++;
      if (m_cnt == AF) begin
        m_cnt = 0;
        m_ch  = (m_ch + 1) % C;
      end
    end else begin
      m_cnt = 0;
      m_ch  = (int'(bus.ch_sel) < C) ? int'(bus.ch_sel) : 0;
    end
    s_w  = bus.ch_data[m_ch*16 +: 16];
    s_dp = bus.dp_mask;
    s_lz = bus.lz_blank;
  endtask

  task automatic randomize_inputs();
    logic [47:0] w;
    for (int i = 0; i < 12; i++)
      w[i*4 +: 4] = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom % 16);
    bus.ch_data  = w;
    bus.dp_mask  = ($urandom % 4 == 0) ? 4'($urandom) : 4'd0;
    bus.ch_sel   = 2'($urandom_range(0, 3));
    bus.lz_blank = 1'($urandom);
  endtask

  task automatic step(input bit rnd);
    logic [3:0] e_an;
    logic [7:0] e_led;
    model_out(e_an, e_led);
    chk("anode", 32'(bus.Anode_Activate), 32'(e_an));
    chk("led", 32'(bus.LED_out), 32'(e_led));
    chk("tick", 32'(bus.frame_tick),
        32'((n >= 1) && ((n - 1) % FRAME == 0)));
    chk("ch", 32'(bus.active_ch), 32'((n == 0) ? 0 : m_ch));
    if (rnd) begin
      if ($urandom % 12 == 0) randomize_inputs();
      if ($urandom % 200 == 0) bus.auto_mode = ~bus.auto_mode;
    end
    if (n % FRAME == 0) model_capture();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic run(input int cycles, input bit rnd);
    for (int i = 0; i < cycles; i++) step(rnd);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_anode", 32'(bus.Anode_Activate), 32'hF);
    chk("rst_led", 32'(bus.LED_out), 32'hFF);
    chk("rst_ch", 32'(bus.active_ch), 32'h0);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    rst_n = 1'b1;
    n     = 0;
    m_ch  = 0;
    m_cnt = 0;
    s_w   = '0;
    s_dp  = '0;
    s_lz  = 1'b0;
  endtask

  initial begin
    bus.ch_data   = {16'hBEEF, 16'h3456, 16'h12AF};
    bus.dp_mask   = 4'b0000;
    bus.ch_sel    = 2'd0;
    bus.auto_mode = 1'b0;
    bus.lz_blank  = 1'b0;
    do_reset();
    run(44, 0);
    bus.ch_data[15:0] = 16'h0000;
    run(52, 0);
    bus.ch_data[15:0] = 16'h0070;
    bus.lz_blank = 1'b1;
    run(64, 0);
    bus.dp_mask = 4'b0100;
    run(64, 0);
    bus.dp_mask  = 4'b0000;
    bus.lz_blank = 1'b0;
    do_reset();
    bus.auto_mode = 1'b1;
    run(7 * FRAME + 8, 0);
    bus.auto_mode = 1'b0;
    bus.ch_sel    = 2'd2;
    run(2 * FRAME, 0);
    bus.ch_sel = 2'd3;
    run(2 * FRAME, 0);
    do_reset();
    run(50, 0);
    do_reset();
    run(4000, 1);
    do_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
